// File: rtl/rf_array_buffer_writer_if.sv
// rf_array_buffer_writer_if: capture control, RF sample stream and buffer write port
// of the RF array buffer writer.
interface rf_array_buffer_writer_if #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 8
);
   logic                    start;
   logic [ADDR_WIDTH-1:0]   base_addr;
   logic [ADDR_WIDTH:0]     capture_len;
   logic                    abort;
   logic                    rf_valid;
   logic [SAMPLE_WIDTH-1:0] rf_sample;
   logic                    rf_ready;
   logic                    buf_write;
   logic [ADDR_WIDTH-1:0]   buf_addr;
   logic [DATA_WIDTH-1:0]   buf_data;
   logic                    busy;
   logic                    done;
   logic                    aborted;
   logic [ADDR_WIDTH:0]     word_count;
   modport slave (
      input  start, base_addr, capture_len, abort, rf_valid, rf_sample,
      output rf_ready, buf_write, buf_addr, buf_data, busy, done, aborted, word_count
   );
   modport master (
      output start, base_addr, capture_len, abort, rf_valid, rf_sample,
      input  rf_ready, buf_write, buf_addr, buf_data, busy, done, aborted, word_count
   );
endinterface

// File: rtl/rf_array_buffer_writer.sv
// rf_array_buffer_writer: packs RF samples into words and writes them to consecutive buffer
// addresses. Define RF_WRITER_PARTIAL_FLUSH_EN to flush a zero-padded partial word on abort.
module rf_array_buffer_writer #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 8
) (
   input logic clk,
   input logic reset,
   rf_array_buffer_writer_if.slave bus
);
   localparam int PACK = DATA_WIDTH / SAMPLE_WIDTH;
   localparam int LW = PACK > 1 ? $clog2(PACK) : 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_DONE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [LW-1:0]         lane_q, lane_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_n, buf_data_q, buf_data_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, buf_addr_q, buf_addr_d;
   logic [ADDR_WIDTH:0]   len_q, len_d, count_q, count_d, count_inc;
   logic                  buf_write_q, buf_write_d, aborted_q, aborted_d;
   logic                  capturing, accept, last_lane, flush;

   assign capturing = state_q == S_CAPTURE;
   assign accept    = capturing && bus.rf_valid;
   assign last_lane = lane_q == LW'(PACK - 1);
   assign count_inc = count_q + 1'b1;

   // Accumulator is cleared after every word, so unfilled lanes of a flushed word read as zero
   always_comb begin
      acc_n = acc_q;
      if (accept) acc_n[int'(lane_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.rf_sample;
   end

`ifdef RF_WRITER_PARTIAL_FLUSH_EN
   assign flush = capturing && bus.abort && !(accept && last_lane) && (accept || lane_q != '0);
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      acc_d       = acc_q;
      base_d      = base_q;
      len_d       = len_q;
      count_d     = count_q;
      aborted_d   = aborted_q;
      buf_write_d = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (bus.start && !capturing) begin
         base_d    = bus.base_addr;
         len_d     = bus.capture_len;
         count_d   = '0;
         aborted_d = 1'b0;
         lane_d    = '0;
         acc_d     = '0;
         state_d   = bus.capture_len == '0 ? S_DONE : S_CAPTURE;
      end else if (capturing) begin
         acc_d = acc_n;
         if (accept) lane_d = last_lane ? '0 : lane_q + LW'(1);
         if ((accept && last_lane) || flush) begin
            buf_write_d = 1'b1;
            buf_addr_d  = base_q + count_q[ADDR_WIDTH-1:0];
            buf_data_d  = acc_n;
            count_d     = count_inc;
            acc_d       = '0;
         end
         if (accept && last_lane && count_inc == len_q) state_d = S_DONE;
         if (bus.abort) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         lane_q      <= '0;
         acc_q       <= '0;
         base_q      <= '0;
         len_q       <= '0;
         count_q     <= '0;
         aborted_q   <= 1'b0;
         buf_write_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         base_q      <= base_d;
         len_q       <= len_d;
         count_q     <= count_d;
         aborted_q   <= aborted_d;
         buf_write_q <= buf_write_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign bus.rf_ready   = capturing;
   assign bus.busy       = capturing;
   assign bus.done       = state_q == S_DONE;
   assign bus.aborted    = aborted_q;
   assign bus.word_count = count_q;
   assign bus.buf_write  = buf_write_q;
   assign bus.buf_addr   = buf_addr_q;
   assign bus.buf_data   = buf_data_q;
endmodule

// File: tb/tb_rf_array_buffer_writer.sv
// tb_rf_array_buffer_writer: randomized capture scenarios checked against a queue-based model
// of the expected buffer writes.
module tb_rf_array_buffer_writer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0, checks = 0, cyc = 0;

   logic [7:0]  acc[$];
   int          acc_cyc[$];
   logic [9:0]  got_addr[$], exp_addr[$];
   logic [31:0] got_data[$], exp_data[$];
   int          got_cyc[$];

`ifdef RF_WRITER_PARTIAL_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   rf_array_buffer_writer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .SAMPLE_WIDTH(8)) bus ();
   rf_array_buffer_writer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .SAMPLE_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.buf_write === 1'b1) begin
      got_addr.push_back(bus.buf_addr);
      got_data.push_back(bus.buf_data);
      got_cyc.push_back(cyc);
   end

   // Expected writes: word w holds samples 4w..4w+3 little-endian, missing samples zero
   function automatic void model(input int base, input int words);
      logic [31:0] d;
      exp_addr.delete();
      exp_data.delete();
      for (int w = 0; w < words; w++) begin
         d = '0;
         for (int l = 0; l < 4; l++) if (w*4 + l < acc.size()) d[l*8 +: 8] = acc[w*4 + l];
         exp_addr.push_back(10'((base + w) % 1024));
         exp_data.push_back(d);
      end
   endfunction

   task automatic clear();
      #1;
      acc.delete(); acc_cyc.delete();
      got_addr.delete(); got_data.delete(); got_cyc.delete();
   endtask

   task automatic do_start(input int base, input int len);
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 10'(base);
      bus.capture_len = 11'(len);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // seq: 0 random, 1 -> 1,2,3.., 2 -> AA,BB,..; abort rides with the abort_at-th accepted sample
   task automatic send(input int n, input int seq, input bit alt, input int gap_pct, input int abort_at);
      int k = 0, guard = 0;
      bit ph = 1'b0;
      while (k < n && guard < 1000) begin
         @(negedge clk);
         guard++;
         ph = !ph;
         bus.rf_valid = alt ? ph : ($urandom_range(99) >= gap_pct);
         bus.rf_sample = seq == 1 ? 8'(k + 1) : seq == 2 ? 8'(8'hAA + k*8'h11) : 8'($urandom);
         bus.abort = 1'b0;
         if (bus.rf_valid && bus.rf_ready) begin
            acc.push_back(bus.rf_sample);
            acc_cyc.push_back(cyc + 1);
            k++;
            if (k == abort_at) bus.abort = 1'b1;
         end
      end
      checks++;
      if (k != n) begin
         errors++;
         $display("FAIL send_timeout: accepted %0d samples, required %0d", k, n);
      end
      @(negedge clk);
      bus.rf_valid = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.rf_ready, bus.buf_write, bus.busy, bus.done, bus.aborted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 00000",
                  {bus.rf_ready, bus.buf_write, bus.busy, bus.done, bus.aborted});
      end
      checks++;
      if (bus.buf_addr !== 10'd0 || bus.buf_data !== 32'd0 || bus.word_count !== 11'd0) begin
         errors++;
         $display("FAIL reset_regs: addr=%0d data=%h count=%0d, required all 0",
                  bus.buf_addr, bus.buf_data, bus.word_count);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      clear();
      do_start(0, 2);
      checks++;
      if (bus.rf_ready !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: rf_ready=%b busy=%b, required 1 1", bus.rf_ready, bus.busy);
      end
      send(8, 1, 1'b0, 0, 0);
      checks++;
      if (bus.done !== 1'b1 || bus.rf_ready !== 1'b0 || bus.word_count !== 11'd2) begin
         errors++;
         $display("FAIL basic_done: done=%b rf_ready=%b count=%0d, required 1 0 2",
                  bus.done, bus.rf_ready, bus.word_count);
      end
      checks++;
      if (acc_cyc[7] - acc_cyc[0] != 7) begin
         errors++;
         $display("FAIL basic_throughput: 8 samples took %0d cycles, required 8", acc_cyc[7] - acc_cyc[0] + 1);
      end
      #1;
      model(0, 2);
      checks++;
      if (got_data.size() != 2) begin
         errors++;
         $display("FAIL basic_writes: got %0d writes, required 2", got_data.size());
      end else begin
         for (int w = 0; w < 2; w++) begin
            checks++;
            if (got_addr[w] !== exp_addr[w] || got_data[w] !== exp_data[w] || got_cyc[w] != acc_cyc[w*4 + 3]) begin
               errors++;
               $display("FAIL basic_word%0d: got %h@%0d cyc %0d, required %h@%0d cyc %0d", w,
                        got_data[w], got_addr[w], got_cyc[w], exp_data[w], exp_addr[w], acc_cyc[w*4 + 3]);
            end
         end
         checks++;
         if (got_data[0] !== 32'h04030201 || got_data[1] !== 32'h08070605) begin
            errors++;
            $display("FAIL basic_const: got %h %h, required 04030201 08070605", got_data[0], got_data[1]);
         end
      end
   endtask

   task automatic test_wrap();
      clear();
      do_start(1023, 2);
      send(8, 0, 1'b0, 0, 0);
      #1;
      model(1023, 2);
      checks++;
      if (got_addr.size() != 2 || got_addr[0] !== 10'd1023 || got_addr[1] !== 10'd0 ||
          got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1]) begin
         errors++;
         $display("FAIL wrap: got %0d writes first addr %0d, required 2 writes at 1023,0",
                  got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 10'd0);
      end
   endtask

   task automatic test_zero_len();
      bit ready_seen = 1'b0;
      clear();
      do_start(7, 0);
      checks++;
      if (bus.done !== 1'b1 || bus.word_count !== 11'd0) begin
         errors++;
         $display("FAIL zero_done: done=%b count=%0d, required 1 0", bus.done, bus.word_count);
      end
      bus.rf_valid = 1'b1;
      bus.abort = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.rf_ready !== 1'b0) ready_seen = 1'b1;
      end
      bus.rf_valid = 1'b0;
      bus.abort = 1'b0;
      #1;
      checks++;
      if (ready_seen || got_addr.size() != 0) begin
         errors++;
         $display("FAIL zero_quiet: rf_ready_seen=%b writes=%0d, required 0 0", ready_seen, got_addr.size());
      end
      checks++;
      if (bus.aborted !== 1'b0 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL abort_outside_capture: aborted=%b done=%b, required 0 1", bus.aborted, bus.done);
      end
   endtask

   task automatic test_toggle();
      clear();
      do_start(100, 1);
      send(4, 0, 1'b1, 0, 0);
      #1;
      model(100, 1);
      checks++;
      if (got_data.size() != 1 || got_data[0] !== exp_data[0] || got_addr[0] !== 10'd100) begin
         errors++;
         $display("FAIL toggle: got %0d writes data %h, required 1 write %h@100",
                  got_data.size(), got_data.size() > 0 ? got_data[0] : 32'h0, exp_data[0]);
      end
   endtask

   task automatic test_abort();
      clear();
      do_start(0, 4);
      send(2, 2, 1'b0, 0, 0);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      checks++;
      if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.rf_ready !== 1'b0 || bus.word_count !== 11'(FLUSH)) begin
         errors++;
         $display("FAIL abort_state: done=%b aborted=%b rf_ready=%b count=%0d, required 1 1 0 %0d",
                  bus.done, bus.aborted, bus.rf_ready, bus.word_count, FLUSH);
      end
      checks++;
      if (got_data.size() != int'(FLUSH) || (FLUSH && (got_data[0] !== 32'h0000BBAA || got_addr[0] !== 10'd0))) begin
         errors++;
         $display("FAIL abort_write: got %0d writes, required %0d (0000bbaa@0 when flushed)",
                  got_data.size(), FLUSH);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int base, len, n, ab, words;
         clear();
         base = $urandom_range(1023);
         len = $urandom_range(1, 4);
         ab = it % 2 ? $urandom_range(1, len*4 - 1) : 0;
         n = ab != 0 ? ab : len*4;
         words = n / 4 + ((ab != 0 && FLUSH && n % 4 != 0) ? 1 : 0);
         do_start(base, len);
         send(n, 0, 1'b0, 30, ab);
         #1;
         model(base, words);
         checks++;
         if (bus.done !== 1'b1 || bus.aborted !== (ab != 0) || bus.word_count !== 11'(words)) begin
            errors++;
            $display("FAIL random%0d_state: done=%b aborted=%b count=%0d, required 1 %b %0d",
                     it, bus.done, bus.aborted, bus.word_count, ab != 0, words);
         end
         checks++;
         if (got_data.size() != words) begin
            errors++;
            $display("FAIL random%0d_count: got %0d writes, required %0d", it, got_data.size(), words);
         end else begin
            for (int w = 0; w < words; w++) begin
               checks++;
               if (got_addr[w] !== exp_addr[w] || got_data[w] !== exp_data[w]) begin
                  errors++;
                  $display("FAIL random%0d_word%0d: got %h@%0d, required %h@%0d", it, w,
                           got_data[w], got_addr[w], exp_data[w], exp_addr[w]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      clear();
      do_start(0, 2);
      send(2, 1, 1'b0, 0, 0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rf_ready, bus.buf_write, bus.busy, bus.done, bus.aborted} !== 5'b0 ||
          bus.word_count !== 11'd0 || got_data.size() != 0) begin
         errors++;
         $display("FAIL reset_mid: flags=%b count=%0d writes=%0d, required 0 0 0",
                  {bus.rf_ready, bus.buf_write, bus.busy, bus.done, bus.aborted}, bus.word_count, got_data.size());
      end
      reset = 1'b1;
      clear();
      do_start(5, 1);
      send(4, 1, 1'b0, 0, 0);
      #1;
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 32'h04030201 || got_addr[0] !== 10'd5) begin
         errors++;
         $display("FAIL reset_restart: got %0d writes data %h, required 1 write 04030201@5",
                  got_data.size(), got_data.size() > 0 ? got_data[0] : 32'h0);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.capture_len = '0;
      bus.abort = 1'b0;
      bus.rf_valid = 1'b0;
      bus.rf_sample = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_zero_len();
      test_toggle();
      test_abort();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
